// File: rtl/prv32_muldiv_ctrl.sv
// prv32_muldiv_ctrl
//   Iterative RV32M multiply/divide sequencer. Borrows the execute-stage ALU
//   for 32 add (multiply) or subtract (restoring divide) iterations and
//   assembles a 64-bit product or a quotient/remainder pair from alu_r/alu_cf.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start, op         request and RV32M funct3 (sampled only in IDLE)
//   rs1, rs2          operands, captured when start is accepted
//   busy, done        busy from PREP through DONE; done pulses in DONE
//   result            operation result, held until the next done
//   alu_own           high while the pipeline must route alu_* to the ALU
//   alu_a/b/alufn     ALU drive (zero / ALU_ADD outside ITER)
//   alu_r, alu_cf     combinational ALU result and carry (SUB: cf = a >= b)
//
// Configuration
//   MULDIV_EARLY_OUT_EN  when defined, divide-by-zero and signed overflow
//                        skip the iterations and go PREP -> DONE.
//
// ALU_ADD / ALU_SUB normally come from defines.v; the fallbacks below keep
// this file self-contained when it is compiled on its own.

`ifndef ALU_ADD
`define ALU_ADD 4'b0000
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b1000
`endif

module prv32_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        alu_own,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_alufn,
    input  logic [31:0] alu_r,
    input  logic        alu_cf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;

    // Captured request
    logic [2:0]  op_q;
    logic [31:0] rs1_q, rs2_q;

    // Datapath: {hi, lo} is the product, or {rem, q} for divide
    logic [31:0] hi, lo;
    logic [31:0] opnd;          // |rs1| for multiply, |rs2| for divide
    logic        neg;           // negate the selected result in FIX
    logic        special;       // result overridden by special_val
    logic [31:0] special_val;

    // ------------------------------------------------------------------
    // PREP decode, from the captured request
    // ------------------------------------------------------------------
    logic        is_div;
    logic        rs1_signed, rs2_signed;
    logic        sign1, sign2;
    logic [31:0] mag1, mag2;
    logic        neg_prep;
    logic        div_zero, div_ovf, special_prep;
    logic [31:0] special_val_prep;

    always_comb begin
        is_div     = op_q[2];
        // Signed rs1: MULH, MULHSU, DIV, REM. Signed rs2: MULH, DIV, REM.
        rs1_signed = is_div ? ~op_q[0] : (op_q == 3'd1 || op_q == 3'd2);
        rs2_signed = is_div ? ~op_q[0] : (op_q == 3'd1);
        sign1      = rs1_signed & rs1_q[31];
        sign2      = rs2_signed & rs2_q[31];
        mag1       = sign1 ? (32'd0 - rs1_q) : rs1_q;
        mag2       = sign2 ? (32'd0 - rs2_q) : rs2_q;
        // Remainder takes the dividend's sign; product and quotient the xor.
        neg_prep   = (is_div && op_q[1]) ? sign1 : (sign1 ^ sign2);

        div_zero     = is_div && (rs2_q == 32'd0);
        div_ovf      = is_div && !op_q[0] && (rs1_q == 32'h8000_0000) &&
                       (rs2_q == 32'hFFFF_FFFF);
        special_prep = div_zero | div_ovf;
        if (div_zero)
            special_val_prep = op_q[1] ? rs1_q : 32'hFFFF_FFFF;
        else
            special_val_prep = op_q[1] ? 32'd0 : 32'h8000_0000;
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [31:0] div_p;
    logic        take;

    always_comb begin
        div_p = {hi[30:0], lo[31]};
        // A set rem[31] means the shifted partial remainder is >= 2^32,
        // so it always exceeds the divisor even though p lost that bit.
        take  = hi[31] | alu_cf;
    end

    // ------------------------------------------------------------------
    // FIX: sign correction and result selection
    // ------------------------------------------------------------------
    logic [63:0] prod_fix;
    logic [31:0] div_sel, div_fix, fix_val;

    always_comb begin
        prod_fix = neg ? (64'd0 - {hi, lo}) : {hi, lo};
        div_sel  = op_q[1] ? hi : lo;
        div_fix  = neg ? (32'd0 - div_sel) : div_sel;
        if (special)
            fix_val = special_val;
        else if (is_div)
            fix_val = div_fix;
        else if (op_q == 3'd0)
            fix_val = prod_fix[31:0];
        else
            fix_val = prod_fix[63:32];
    end

    // ------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_nx  = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        alu_own   = (state == S_ITER);
        alu_a     = 32'd0;
        alu_b     = 32'd0;
        alu_alufn = `ALU_ADD;

        case (state)
            S_IDLE: if (start) state_nx = S_PREP;
`ifdef MULDIV_EARLY_OUT_EN
            S_PREP: state_nx = special_prep ? S_DONE : S_ITER;
`else
            S_PREP: state_nx = S_ITER;
`endif
            S_ITER: begin
                alu_b = opnd;
                if (is_div) begin
                    alu_a     = div_p;
                    alu_alufn = `ALU_SUB;
                end else begin
                    alu_a     = hi;
                end
                if (cnt == 5'd31) state_nx = S_FIX;
            end
            S_FIX:  state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Control state: reset discards any in-flight operation
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 5'd0;
            result <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= (state == S_ITER) ? cnt + 5'd1 : 5'd0;
            if (state == S_FIX)
                result <= fix_val;
`ifdef MULDIV_EARLY_OUT_EN
            if (state == S_PREP && special_prep)
                result <= special_val_prep;
`endif
        end
    end

    // Datapath registers
    // NOTE: these carry no reset; each is loaded in IDLE or PREP before any
    // state that reads it, and the FSM reset alone makes the block safe.
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (start) begin
                    op_q  <= op;
                    rs1_q <= rs1;
                    rs2_q <= rs2;
                end
            end
            S_PREP: begin
                hi          <= 32'd0;
                lo          <= is_div ? mag1 : mag2;
                opnd        <= is_div ? mag2 : mag1;
                neg         <= neg_prep;
                special     <= special_prep;
                special_val <= special_val_prep;
            end
            S_ITER: begin
                if (is_div) begin
                    hi <= take ? alu_r : div_p;
                    lo <= {lo[30:0], take};
                end else if (lo[0]) begin
                    hi <= {alu_cf, alu_r[31:1]};
                    lo <= {alu_r[0], lo[31:1]};
                end else begin
                    hi <= {1'b0, hi[31:1]};
                    lo <= {hi[0], lo[31:1]};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/prv32_muldiv_ctrl.md
# prv32_muldiv_ctrl

Iterative RV32M multiply/divide sequencer for the pipelined core. It borrows the execute-stage ALU and drives its `a`, `b` and `alufn` inputs for 32 add or subtract iterations per operation. It uses the ALU's `r` and `cf` outputs to build a 64-bit product or a quotient/remainder pair. The execute stage holds the pipeline while `busy` is high and muxes the ALU inputs to this block while `alu_own` is high.

## Interface
- No parameters. ALU operation codes are the `ALU_ADD` and `ALU_SUB` macros from `defines.v`.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  operation request; sampled only in IDLE
- op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1  in  32  dividend or multiplicand; captured on accepted start
- rs2  in  32  divisor or multiplier; captured on accepted start
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse; `result` is valid in this cycle
- result  out  32  operation result; holds its value until the next done
- alu_own  out  1  high in ITER; the pipeline must route alu_* to the shared ALU
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_alufn  out  4  ALU function select
- alu_r  in  32  ALU result, combinational from alu_a/alu_b/alu_alufn
- alu_cf  in  1  ALU carry; on SUB, 1 means a ≥ b unsigned

## Operation
- FSM states: IDLE, PREP, ITER, FIX, DONE.
  - IDLE → PREP on start.
  - PREP → ITER.
  - ITER → FIX after 32 iterations; a 5-bit counter runs 0..31.
  - FIX → DONE.
  - DONE → IDLE.
- start is ignored in every state except IDLE. No queueing.
- PREP:
  - Convert operands to magnitudes. rs1 is treated as signed for MULH, MULHSU, DIV and REM; rs2 is treated as signed for MULH, DIV and REM.
  - Record the result sign: product sign = sign1 ^ sign2. Quotient sign = sign1 ^ sign2. Remainder sign = sign1.
  - Clear the accumulator.
- Multiply iteration, with registers {hi, lo}, lo initially holding |rs2|:
  - alu_a = hi, alu_b = |rs1|, alufn = `ALU_ADD`.
  - If lo[0] = 1: {hi, lo} ← {alu_cf, alu_r, lo[31:1]}.
  - Otherwise: {hi, lo} ← {1'b0, hi, lo[31:1]}.
- Divide iteration (restoring), with rem initially 0 and q initially |rs1|:
  - p = {rem[30:0], q[31]}; alu_a = p, alu_b = |rs2|, alufn = `ALU_SUB`.
  - take = rem[31] | alu_cf. If take: rem ← alu_r. Otherwise: rem ← p.
  - q ← {q[30:0], take}.
- FIX: negate the 64-bit product, the quotient or the remainder per the recorded sign, then register `result`.
  - MUL returns lo.
  - MULH, MULHSU and MULHU return hi.
  - DIV and DIVU return q.
  - REM and REMU return rem.
- Special cases, overriding the iterative result:
  - rs2 = 0: quotient = 0xFFFFFFFF, remainder = rs1.
  - Signed DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Outside ITER: alu_a = 0, alu_b = 0, alu_alufn = `ALU_ADD`, alu_own = 0.

## Timing
- Reset values: busy 0, done 0, result 0, alu_own 0, alu_a 0, alu_b 0, alu_alufn `ALU_ADD`. State is IDLE and the counter is 0.
- Let start be accepted at edge E0. Then:
  - PREP occupies cycle 1.
  - ITER occupies cycles 2–33.
  - FIX occupies cycle 34.
  - DONE occupies cycle 35, with done = 1, busy = 1 and result valid.
- Total latency is 35 cycles. The earliest next start is sampled in cycle 36.
- rst asserted in any state: at the next edge all outputs take their reset values and any in-flight operation is discarded without a done pulse.
- rst and start asserted together: rst wins.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: special cases go PREP → DONE directly. done occurs in cycle 2 after E0, and alu_own is never asserted for that operation.
- `MULDIV_EARLY_OUT_EN` undefined: special cases run the full 35-cycle sequence, and the result is overridden in FIX. Results are identical in both builds; only latency differs.

## Test plan
- MUL, rs1 = 7, rs2 = 0xFFFFFFFD → result 0xFFFFFFEB; done exactly 35 cycles after start; alu_own high for exactly 32 cycles.
- MULHU, rs1 = rs2 = 0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU with the same operands → 0xFFFFFFFF.
- DIV, rs1 = 0xFFFFFFF9 (−7), rs2 = 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU, rs1 = 100, rs2 = 7 → 14. REMU with the same operands → 2.
- DIVU rs1 = 0x1234, rs2 = 0 → 0xFFFFFFFF. REM rs1 = 0x1234, rs2 = 0 → 0x1234. DIV rs1 = 0x80000000, rs2 = 0xFFFFFFFF → 0x80000000, and REM with those operands → 0.
  - Latency is 2 cycles with `MULDIV_EARLY_OUT_EN` and 35 cycles without it.
- rst pulsed at iteration 10 of a DIVU → busy and alu_own low at the next edge and no done pulse. A following MUL, rs1 = 3, rs2 = 5 → 15.
- start held high throughout an operation → exactly one done pulse and operands unchanged. The second operation is accepted in the IDLE cycle after DONE.
